// File: rtl/fp32_divider_if.sv
// Operand/result bundle for the sequential binary32 divider.
// master: drives num/den, observes rdy/quo.  slave: the divider itself.
// Ports: num[31:0], den[31:0] (operands), rdy (result valid), quo[31:0] (result).
interface fp32_divider_if;
    logic [31:0] num;
    logic [31:0] den;
    logic        rdy;
    logic [31:0] quo;

    modport master (output num, output den, input rdy, input quo);
    modport slave  (input num, input den, output rdy, output quo);
endinterface

// File: rtl/fp32_divider.sv
// Sequential IEEE-754 binary32 divider (quo = num / den, RNE), exact mantissa long division.
// Latency: rdy rises QBITS+2 edges after LOAD (28 at default); special operands 2 edges with early path.
// No backpressure: runs free, re-evaluates when num/den differ from the captured copy once DONE.
//
// Ports: clk (rising edge), rst (async, active-low), bus (fp32_divider_if.slave: num, den in; rdy, quo out).
// Optional macro FP32_DIV_EARLY_SPECIAL_EN: zero/inf/NaN/denormal operands bypass DIV/RND and
// the result is loaded at the LOAD edge; result values are identical either way.
module fp32_divider #(
    parameter int QBITS = 26    // quotient bits: 24 mantissa + guard + round (>= 26)
) (
    input  logic          clk,
    input  logic          rst,
    fp32_divider_if.slave bus
);

    localparam int CW = $clog2(QBITS + 1);

    typedef enum logic [1:0] {LOAD, DIV, RND, DONE} state_t;

    state_t state, state_nxt;

    // Captured operands and working registers
    logic [31:0]       num_q, den_q;
    logic              sign_q;
    logic              special_q;
    logic [31:0]       special_val_q;
    logic signed [9:0] exp_q;
    logic [23:0]       mb_q;
    logic [25:0]       rem_q;
    logic [QBITS-1:0]  q_q;
    logic [CW-1:0]     cnt_q;
    logic [31:0]       quo_q;
    logic              rdy_q;

    // ------------------------------------------------------------------
    // Input unpack and classification (used at the LOAD edge)
    // ------------------------------------------------------------------
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic              in_sign, in_special;
    logic [31:0]       in_special_val;
    logic [23:0]       ma, mb;
    logic              pre_shift;
    logic signed [9:0] exp_in;
    logic [25:0]       rem_init;
    logic              changed;

    always_comb begin
        ea      = bus.num[30:23];
        eb      = bus.den[30:23];
        fa      = bus.num[22:0];
        fb      = bus.den[22:0];
        a_nan   = (&ea) && (|fa);
        b_nan   = (&eb) && (|fb);
        a_inf   = (&ea) && !(|fa);
        b_inf   = (&eb) && !(|fb);
        // Denormals are flushed: a zero exponent field is treated as zero.
        a_zero  = (ea == 8'd0);
        b_zero  = (eb == 8'd0);
        in_sign = bus.num[31] ^ bus.den[31];

        in_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
            in_special_val = 32'h7fc0_0000;
        else if (b_zero || a_inf)
            in_special_val = {in_sign, 8'hff, 23'd0};
        else
            in_special_val = {in_sign, 31'd0};

        ma        = {1'b1, fa};
        mb        = {1'b1, fb};
        // Pre-shifting the smaller numerator keeps the quotient in [1,2),
        // so the first developed bit is always the hidden one.
        pre_shift = (ma < mb);
        exp_in    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
                    - (pre_shift ? 10'sd1 : 10'sd0);
        rem_init  = pre_shift ? {1'b0, ma, 1'b0} : {2'b00, ma};

        changed   = (bus.num != num_q) || (bus.den != den_q);
    end

    // ------------------------------------------------------------------
    // Restoring division step
    // ------------------------------------------------------------------
    logic        ge;
    logic [25:0] diff;

    always_comb begin
        ge   = (rem_q >= {2'b00, mb_q});
        diff = rem_q - {2'b00, mb_q};
    end

    // ------------------------------------------------------------------
    // Round to nearest even, renormalise, range check
    // ------------------------------------------------------------------
    logic [23:0]       mant;
    logic              g_bit, r_bit, s_bit, round_up;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic signed [9:0] exp_r;
    logic [31:0]       rounded;

    always_comb begin
        mant     = q_q[QBITS-1 -: 24];
        g_bit    = q_q[QBITS-25];
        r_bit    = q_q[QBITS-26];
        // Any quotient bits below round (QBITS > 26) fold into sticky with the remainder.
        s_bit    = (rem_q != 26'd0) || ((q_q << 26) != '0);
        round_up = g_bit & (r_bit | s_bit | mant[0]);
        sum      = {1'b0, mant} + {24'd0, round_up};
        frac     = sum[24] ? sum[23:1] : sum[22:0];
        exp_r    = exp_q + (sum[24] ? 10'sd1 : 10'sd0);
        if (exp_r > 10'sd254)
            rounded = {sign_q, 8'hff, 23'd0};
        else if (exp_r < 10'sd1)
            rounded = {sign_q, 31'd0};
        else
            rounded = {sign_q, exp_r[7:0], frac};
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
`ifdef FP32_DIV_EARLY_SPECIAL_EN
                state_nxt = in_special ? DONE : DIV;
`else
                state_nxt = DIV;
`endif
            end
            DIV:     state_nxt = (cnt_q == CW'(QBITS - 1)) ? RND : DIV;
            RND:     state_nxt = DONE;
            DONE:    state_nxt = changed ? LOAD : DONE;
            default: state_nxt = LOAD;
        endcase
    end

    // FSM: outputs / datapath controls
    logic        ld_en, div_en, quo_ld, rdy_d;
    logic [31:0] quo_d;

    always_comb begin
        ld_en  = 1'b0;
        div_en = 1'b0;
        quo_ld = 1'b0;
        quo_d  = quo_q;
        rdy_d  = 1'b0;
        case (state)
            LOAD: begin
                ld_en = 1'b1;
`ifdef FP32_DIV_EARLY_SPECIAL_EN
                if (in_special) begin
                    quo_ld = 1'b1;
                    quo_d  = in_special_val;
                end
`endif
            end
            DIV: div_en = 1'b1;
            RND: begin
                quo_ld = 1'b1;
                quo_d  = special_q ? special_val_q : rounded;
                rdy_d  = 1'b1;
            end
            DONE:    rdy_d = !changed;
            default: rdy_d = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q         <= 32'd0;
            den_q         <= 32'd0;
            sign_q        <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= 32'd0;
            exp_q         <= 10'sd0;
            mb_q          <= 24'd0;
            rem_q         <= 26'd0;
            q_q           <= '0;
            cnt_q         <= '0;
            quo_q         <= 32'd0;
            rdy_q         <= 1'b0;
        end else begin
            if (ld_en) begin
                num_q         <= bus.num;
                den_q         <= bus.den;
                sign_q        <= in_sign;
                special_q     <= in_special;
                special_val_q <= in_special_val;
                exp_q         <= exp_in;
                mb_q          <= mb;
                rem_q         <= rem_init;
                q_q           <= '0;
                cnt_q         <= '0;
            end
            if (div_en) begin
                rem_q <= ge ? {diff[24:0], 1'b0} : {rem_q[24:0], 1'b0};
                q_q   <= {q_q[QBITS-2:0], ge};
                cnt_q <= cnt_q + 1'b1;
            end
            if (quo_ld)
                quo_q <= quo_d;
            rdy_q <= rdy_d;
        end
    end

    assign bus.quo = quo_q;
    assign bus.rdy = rdy_q;

endmodule

// File: tb/tb_fp32_divider.sv
// Directed bench for fp32_divider: hand-computed binary32 quotients, latency, restart and reset.
module tb_fp32_divider;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp32_divider_if bus();

    fp32_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int edges;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Counts rising edges until rdy is seen high, bounded.
    task automatic wait_rdy(output int e);
        e = 0;
        do begin
            @(posedge clk);
            #1;
            e++;
        end while (!bus.rdy && e < 200);
    endtask

    // Apply a new operand pair while DONE; rdy must drop on the first edge,
    // then the result follows (29 edges in total for non-special operands).
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_v, input bit chk_lat);
        int e;
        @(negedge clk);
        bus.num = a;
        bus.den = b;
        @(posedge clk);
        #1;
        check($sformatf("%s_drop", tag), {31'd0, bus.rdy}, 32'd0);
        wait_rdy(e);
        check($sformatf("%s_rdy", tag), {31'd0, bus.rdy}, 32'd1);
        if (chk_lat)
            check($sformatf("%s_lat", tag), 32'(e + 1), 32'd29);
        check($sformatf("%s_quo", tag), bus.quo, exp_v);
    endtask

    initial begin
        bus.num = 32'h4080_0000;
        bus.den = 32'h4000_0000;
        rst     = 1'b1;
        #2 rst  = 1'b0;
        #1;
        check("reset_rdy", {31'd0, bus.rdy}, 32'd0);
        check("reset_quo", bus.quo, 32'd0);

        // 4 / 2 from reset release
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_rdy(edges);
        check("div4_2_lat", 32'(edges), 32'd28);
        check("div4_2_quo", bus.quo, 32'h4000_0000);

        // Held in DONE while operands are stable
        repeat (3) @(posedge clk);
        #1;
        check("hold_rdy", {31'd0, bus.rdy}, 32'd1);
        check("hold_quo", bus.quo, 32'h4000_0000);

        run("div4_3",     32'h4080_0000, 32'h4040_0000, 32'h3faa_aaab, 1'b1);
        run("div193_386", 32'h4341_0000, 32'h43c1_0000, 32'h3f00_0000, 1'b1);
        run("div1_3",     32'h3f80_0000, 32'h4040_0000, 32'h3eaa_aaab, 1'b1);
        run("zero_num",   32'h0000_0000, 32'h4f00_0000, 32'h0000_0000, 1'b0);
        run("div_by0",    32'h4f00_0000, 32'h0000_0000, 32'h7f80_0000, 1'b0);
        run("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h7fc0_0000, 1'b0);
        run("neg_pos",    32'hcf00_0000, 32'h4f00_0000, 32'hbf80_0000, 1'b1);
        run("neg_neg",    32'hcf00_0000, 32'hcf00_0000, 32'h3f80_0000, 1'b1);
        run("inf_inf",    32'h7f80_0000, 32'hff80_0000, 32'h7fc0_0000, 1'b0);
        run("nan_in",     32'h7fc0_0001, 32'h3f80_0000, 32'h7fc0_0000, 1'b0);
        run("neg_by0",    32'hbf80_0000, 32'h0000_0000, 32'hff80_0000, 1'b0);
        run("fin_inf",    32'h3f80_0000, 32'hff80_0000, 32'h8000_0000, 1'b0);
        run("overflow",   32'h7f00_0000, 32'h3e80_0000, 32'h7f80_0000, 1'b1);
        run("underflow",  32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
        run("denorm",     32'h0040_0000, 32'h3f80_0000, 32'h0000_0000, 1'b0);
        run("neg_denorm", 32'h8040_0000, 32'h3f80_0000, 32'h8000_0000, 1'b0);

        // Reset at cycle 10 of DIV: 3 / 4 = 0.75
        @(negedge clk);
        bus.num = 32'h4040_0000;
        bus.den = 32'h4080_0000;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_rdy", {31'd0, bus.rdy}, 32'd0);
        check("midrst_quo", bus.quo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_rdy(edges);
        check("midrst_lat", 32'(edges), 32'd28);
        check("midrst_res", bus.quo, 32'h3f40_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
